// File: rtl/seq_signed_divider.sv
// -----------------------------------------------------------------------------
// seq_signed_divider
//
// Sequential signed restoring divider. The operands are two's-complement. The
// result is returned in sign-magnitude form, with the same layout as the shift-add
// signed multiplier (a magnitude bus plus a separate sign flag). Division
// truncates toward zero. The divider produces one quotient bit per clock, so a
// full operation takes DW clock edges from the accept edge until done is visible.
//
// Ports:
//   clk          in   1   system clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   start        in   1   request pulse, sampled only when not busy
//   dividend     in   DW  two's-complement dividend, captured on accept
//   divisor      in   VW  two's-complement divisor, captured on accept
//   quotient     out  DW  quotient magnitude (unsigned)
//   q_sign       out  1   quotient sign, 1 = negative
//   remainder    out  VW  remainder magnitude (unsigned)
//   r_sign       out  1   remainder sign, 1 = negative
//   busy         out  1   high while iterating
//   done         out  1   result valid, held until the next accepted start
//   div_by_zero  out  1   last accepted operation had a zero divisor
// -----------------------------------------------------------------------------
module seq_signed_divider #(
  parameter int DW = 16,
  parameter int VW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic          q_sign,
  output logic [VW-1:0] remainder,
  output logic          r_sign,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [DW-1:0] dvd_reg;   // dividend magnitude; its MSB feeds the next step
  logic [VW-1:0] dvs_reg;   // divisor magnitude
  logic [VW-1:0] rem_reg;   // partial remainder, always < dvs_reg between steps
  logic [DW-1:0] quo_reg;   // quotient bits collected so far
  logic [CW-1:0] cnt_reg;
  logic          sd_reg;
  logic          sv_reg;
  logic          zero_reg;  // divisor was zero at accept

  logic          accept;
  logic          last_step;
  logic [DW-1:0] dvd_mag;
  logic [VW-1:0] dvs_mag;
  logic [VW:0]   trial;
  logic          ge;
  logic [VW-1:0] rem_step;
  logic [DW-1:0] quo_step;

  // Take the two's complement only when the MSB is set. The most-negative
  // value maps onto itself, and that bit pattern reads as the correct
  // unsigned magnitude.
  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
    if (dividend[DW-1]) begin
      dvd_mag = ~dividend + DW'(1);
    end
    if (divisor[VW-1]) begin
      dvs_mag = ~divisor + VW'(1);
    end
  end

  // One restoring step. The partial remainder shifts left by one bit and takes
  // in the next dividend bit, so it needs VW+1 bits. After a subtraction the
  // value is again below the divisor, so keeping VW bits loses nothing.
  always_comb begin
    trial    = {rem_reg, dvd_reg[DW-1]};
    ge       = (trial >= {1'b0, dvs_reg});
    rem_step = ge ? VW'(trial - {1'b0, dvs_reg}) : VW'(trial);
    quo_step = {quo_reg[DW-2:0], ge};
  end

  // A zero divisor needs only one BUSY cycle. Otherwise the last step is the
  // DW-th iteration.
  assign accept    = start && (state_reg != BUSY);
  assign last_step = (state_reg == BUSY) && (zero_reg || (cnt_reg == CW'(DW - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        if (last_step) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_next = BUSY;
      end
      default: state_next = IDLE;
    endcase
  end

  // The datapath and the result registers. The outputs change only at the
  // completing edge, so no partial result is ever visible on them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_reg     <= '0;
      dvs_reg     <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      sd_reg      <= 1'b0;
      sv_reg      <= 1'b0;
      zero_reg    <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_reg     <= dvd_mag;
      dvs_reg     <= dvs_mag;
      rem_reg     <= '0;
      quo_reg     <= '0;
      cnt_reg     <= '0;
      sd_reg      <= dividend[DW-1];
      sv_reg      <= divisor[VW-1];
      zero_reg    <= (divisor == '0);
      div_by_zero <= 1'b0;
    end else if (state_reg == BUSY) begin
      if (zero_reg) begin
        quotient    <= '1;
        remainder   <= '0;
        q_sign      <= 1'b0;
        r_sign      <= 1'b0;
        div_by_zero <= 1'b1;
      end else begin
        dvd_reg <= {dvd_reg[DW-2:0], 1'b0};
        rem_reg <= rem_step;
        quo_reg <= quo_step;
        cnt_reg <= cnt_reg + CW'(1);
        if (last_step) begin
          quotient  <= quo_step;
          remainder <= rem_step;
          // A zero magnitude always carries a positive sign.
          q_sign    <= (sd_reg ^ sv_reg) && (quo_step != '0);
          r_sign    <= sd_reg && (rem_step != '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_signed_divider.sv
module tb_seq_signed_divider;

  localparam int DW = 16;
  localparam int VW = 8;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic [DW-1:0] quotient;
  logic          q_sign;
  logic [VW-1:0] remainder;
  logic          r_sign;
  logic          busy;
  logic          done;
  logic          div_by_zero;

  int n_pass  = 0;
  int n_total = 0;

  seq_signed_divider #(.DW(DW), .VW(VW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .q_sign      (q_sign),
    .remainder   (remainder),
    .r_sign      (r_sign),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] a;
    logic [VW-1:0] b;
    logic [DW-1:0] q;
    logic          qs;
    logic [VW-1:0] r;
    logic          rs;
    logic          dbz;
    int            lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // This task accepts one operation and checks the state right after the
  // accept edge. It then counts the edges until done rises, giving up after
  // 40 edges.
  task automatic do_op(input logic [DW-1:0] a, input logic [VW-1:0] b, output int lat);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("accept_state", {29'd0, busy, done, div_by_zero}, 32'b100);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [DW-1:0] q_hold;

    vecs[0]  = '{16'd100,  8'd7,   16'd14,   1'b0, 8'd2, 1'b0, 1'b0, 16};
    vecs[1]  = '{16'hFF9C, 8'd7,   16'd14,   1'b1, 8'd2, 1'b1, 1'b0, 16};
    vecs[2]  = '{16'd100,  8'hF9,  16'd14,   1'b1, 8'd2, 1'b0, 1'b0, 16};
    vecs[3]  = '{16'h8000, 8'hFF,  16'h8000, 1'b0, 8'd0, 1'b0, 1'b0, 16};
    vecs[4]  = '{16'd3,    8'h80,  16'd0,    1'b0, 8'd3, 1'b0, 1'b0, 16};
    vecs[5]  = '{16'd5,    8'd0,   16'hFFFF, 1'b0, 8'd0, 1'b0, 1'b1, 1};
    vecs[6]  = '{16'd9,    8'd3,   16'd3,    1'b0, 8'd0, 1'b0, 1'b0, 16};
    vecs[7]  = '{16'hFFF9, 8'd2,   16'd3,    1'b1, 8'd1, 1'b1, 1'b0, 16};
    vecs[8]  = '{16'hFFFA, 8'd3,   16'd2,    1'b1, 8'd0, 1'b0, 1'b0, 16};
    vecs[9]  = '{16'd0,    8'hFB,  16'd0,    1'b0, 8'd0, 1'b0, 1'b0, 16};
    vecs[10] = '{16'h7FFF, 8'h7F,  16'd258,  1'b0, 8'd1, 1'b0, 1'b0, 16};
    vecs[11] = '{16'h8000, 8'h7F,  16'd258,  1'b1, 8'd2, 1'b1, 1'b0, 16};
    vecs[12] = '{16'hFFFF, 8'h80,  16'd0,    1'b0, 8'd1, 1'b1, 1'b0, 16};

    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, div_by_zero, q_sign, r_sign, quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].a, vecs[i].b, lat);
      chk("latency", lat, vecs[i].lat);
      chk("quotient", {16'd0, quotient}, {16'd0, vecs[i].q});
      chk("q_sign", {31'd0, q_sign}, {31'd0, vecs[i].qs});
      chk("remainder", {24'd0, remainder}, {24'd0, vecs[i].r});
      chk("r_sign", {31'd0, r_sign}, {31'd0, vecs[i].rs});
      chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, vecs[i].dbz});
      $display("op %0d: %h / %h -> q=%h qs=%b r=%h rs=%b dbz=%b lat=%0d",
               i, vecs[i].a, vecs[i].b, quotient, q_sign, remainder, r_sign, div_by_zero, lat);
    end

    // The result must hold while the inputs wander and start stays low.
    q_hold = quotient;
    @(negedge clk);
    dividend = 16'h1234;
    divisor  = 8'h05;
    repeat (4) @(posedge clk);
    #1;
    chk("hold_quotient", {16'd0, quotient}, {16'd0, q_hold});
    chk("hold_done", {31'd0, done}, 32'd1);

    // A start pulse in the middle of an operation must be ignored.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    repeat (4) begin @(posedge clk); #1; lat++; end
    @(negedge clk);
    dividend = 16'd50;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start = 1'b0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("busy_start_latency", lat, 16);
    chk("busy_start_quotient", {16'd0, quotient}, 32'd14);
    chk("busy_start_remainder", {24'd0, remainder}, 32'd2);
    $display("ignored start: q=%0d r=%0d lat=%0d", quotient, remainder, lat);

    // Hold start high from DONE onward. Each DONE visit must re-trigger a new
    // operation.
    @(negedge clk);
    dividend = 16'd9;
    divisor  = 8'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b_done_drop", {30'd0, busy, done}, 32'b10);
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("b2b_latency", lat, 16);
    chk("b2b_quotient", {16'd0, quotient}, 32'd3);
    @(posedge clk);
    #1;
    chk("retrigger", {30'd0, busy, done}, 32'b10);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("retrigger_quotient", {16'd0, quotient}, 32'd3);
    $display("back-to-back: q=%0d lat=%0d", quotient, lat);

    // Assert the asynchronous reset between edges, in the middle of an operation.
    @(negedge clk);
    dividend = 16'd100;
    divisor  = 8'd7;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", {busy, done, div_by_zero, q_sign, r_sign, quotient, remainder}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);
    do_op(16'd100, 8'd7, lat);
    chk("post_reset_latency", lat, 16);
    chk("post_reset_quotient", {16'd0, quotient}, 32'd14);
    chk("post_reset_remainder", {24'd0, remainder}, 32'd2);
    $display("after reset: q=%0d r=%0d lat=%0d", quotient, remainder, lat);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Sequential signed restoring divider; the inverse operation to the team's shift-add signed multiplier.
- Takes a two's-complement dividend and divisor, computes truncating division one quotient bit per clock, and reports the result in sign-magnitude form.
- Result format matches the multiplier: magnitude bus plus separate sign flag.
- Sits beside the multiplier in the arithmetic datapath, using the same start/done handshake.

Parameters:
- DW, 16, dividend width and quotient magnitude width.
- VW, 8, divisor width and remainder magnitude width. Constraint: VW <= DW.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request pulse; sampled only when not busy.
- dividend  in  DW  two's-complement dividend; captured on accept edge.
- divisor  in  VW  two's-complement divisor; captured on accept edge.
- quotient  out  DW  quotient magnitude, unsigned.
- q_sign  out  1  quotient sign (1 = negative).
- remainder  out  VW  remainder magnitude, unsigned.
- r_sign  out  1  remainder sign (1 = negative).
- busy  out  1  high while iterating.
- done  out  1  result valid; held until next accepted start.
- div_by_zero  out  1  last accepted operation had divisor == 0.

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - State returns to IDLE.
  - quotient, remainder, q_sign, r_sign, busy, done, div_by_zero all 0.
  - Iteration counter and internal registers cleared.
  - No partial result is ever presented.
- States: IDLE, BUSY, DONE. DONE behaves as IDLE except done = 1.
- Accept:
  - Occurs at edge E0 when start = 1 and state is IDLE or DONE.
  - Register magnitudes |dividend| (DW bits unsigned) and |divisor| (VW bits unsigned). Two's complement is applied only when the MSB is set. The most-negative input magnitude (e.g. 16'h8000 = 32768) fits unsigned.
  - Latch sd = dividend[DW-1] and sv = divisor[VW-1].
  - Clear done and div_by_zero; counter = 0.
- Divisor zero at accept:
  - Go directly to DONE at E1 with div_by_zero = 1, quotient = all ones, remainder = 0, q_sign = 0, r_sign = 0.
  - busy is high only between E0 and E1.
- Otherwise, go to BUSY with busy = 1. Each BUSY edge performs one restoring step:
  - Partial remainder (VW+1 bits) shifts left, taking in the next dividend bit, MSB first.
  - If partial remainder >= |divisor|, subtract and shift in quotient bit 1; else shift in 0.
- Completion:
  - Exactly DW iterations, at E1..EDW (E16 at defaults).
  - At EDW: quotient and remainder registered, state goes to DONE, busy = 0, done = 1.
  - Latency from accept edge to done visible = DW edges (16).
- Sign rules (truncation toward zero):
  - q_sign = sd ^ sv, forced to 0 if quotient == 0.
  - r_sign = sd, forced to 0 if remainder == 0.
- start while BUSY is ignored; inputs may change freely while busy with no effect.
- start high in DONE is accepted as a new operation; done drops at that edge, allowing back-to-back operations.
- start held high continuously re-triggers on every DONE visit.
- Outputs are stable from done rising until the next accept edge or reset.
- No overflow case exists at defaults: |quotient| <= 32768 fits DW bits unsigned, and |remainder| < |divisor| <= 128 fits VW bits.

Test Plan:
1. dividend = 100, divisor = 7, start pulse at E0 -> busy for E0..E16; done = 1 after E16; quotient = 14, remainder = 2, q_sign = 0, r_sign = 0.
2. dividend = -100 (16'hFF9C), divisor = 7 -> quotient = 14, q_sign = 1, remainder = 2, r_sign = 1. Also dividend = 100, divisor = -7 (8'hF9) -> q_sign = 1, r_sign = 0.
3. dividend = -32768 (16'h8000), divisor = -1 (8'hFF) -> quotient = 16'h8000, q_sign = 0, remainder = 0, r_sign = 0. Also dividend = 3, divisor = -128 -> quotient = 0, q_sign = 0, remainder = 3, r_sign = 0.
4. dividend = 5, divisor = 0 -> done and div_by_zero high after E1; quotient = 16'hFFFF, remainder = 0. Next op 9 / 3 -> div_by_zero cleared at its accept edge; quotient = 3.
5. start pulsed again at E5 with different operands while busy -> ignored; result still matches the first operation. start re-asserted in DONE -> done drops at that edge; second result valid 16 edges later.
6. rst_n pulled low at E8 mid-operation (asynchronously, between edges) -> all outputs 0 immediately. After release, with no start, done stays 0; a fresh 100 / 7 completes correctly.
